pow2_divide_sequencer: RTL and testbench
========================================

Name: pow2_divide_sequencer

Overview:
- Multi-cycle signed divide-by-2^S engine with a runtime shift amount S.
- Performs one arithmetic right shift by 1 bit per clock on an internal register, sequenced by a small FSM.
- Valid/ready handshake on both sides.
- Sits between a requester and its consumer wherever a full barrel shifter is too costly.

Parameters:
- N, 8, data width (signed two's complement).
- SW, $clog2(N), width of the shift-amount field; legal S range is 0..N-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  engine can accept a request.
- in_a  input  N  signed dividend.
- in_s  input  SW  shift amount S.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_res  output  N  signed result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE → SHIFT when a request is accepted with S>0.
  - IDLE → DONE when a request is accepted with S==0.
  - SHIFT → DONE after S shift cycles.
  - DONE → IDLE when out_valid && out_ready.
- Reset (async, rst=1): state=IDLE, data register=0, count=0, out_valid=0, out_res=0, busy=0. in_ready=1 from the first cycle after reset deasserts.
- in_ready = (state==IDLE). Requests are never accepted outside IDLE; there is no DONE→accept bypass.
- Accept edge (in_valid && in_ready):
  - data_reg <= in_a (bias applied only with the optional feature).
  - cnt <= in_s.
- SHIFT, each cycle:
  - data_reg <= {data_reg[N-1], data_reg[N-1:1]}.
  - cnt <= cnt-1.
  - When cnt==1, the next state is DONE.
- Latency: out_valid rises S+1 cycles after the accept edge. Example: S=0 gives 1 cycle; S=3 gives 4 cycles.
- Throughput: one result per S+2 cycles with out_ready held high.
- DONE:
  - out_valid=1 and out_res=data_reg.
  - Both are held stable while out_ready=0, for an unbounded number of cycles.
- out_res outside DONE: holds its last value. The value is don't-care for the consumer; verification checks it only when out_valid=1.
- Default result without the optional feature: floor(a / 2^S), i.e. identical to a >>> S.
- Sign handling:
  - The sign bit is replicated on every shift.
  - Negative inputs converge to -1 and never to 0.
  - Positive inputs converge to 0.
- in_s ≥ N cannot occur because SW=$clog2(N). For a non-power-of-two N, in_s values ≥ N are saturated to N-1 at accept.
- in_valid while busy: ignored; in_a and in_s are not sampled.
- rst asserted mid-SHIFT or in DONE: immediate return to IDLE and out_valid=0. The result is lost and no partial result is ever presented.

Optional Feature:
- Macro: POW2_DIVIDE_ROUND_TO_ZERO_EN.
- When defined:
  - At accept, if in_a is negative, data_reg <= in_a + (2^S - 1), computed in N bits.
  - This cannot overflow: worst case is -1 + 2^(N-1) - 1.
  - The result then equals truncating signed division a / 2**S, rounding toward zero.
  - Non-negative inputs are unaffected.
- When undefined:
  - No adder is instantiated.
  - The result rounds toward minus infinity.
- Latency is identical in both builds.

Decomposition:
- Shared package pow2_divide_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - The reset-value constant for data_reg.
- One sub-module, arithmetic_right_shift_by_1:
  - Combinational, parameter N.
  - Output = {a[N-1], a[N-1:1]}.
  - Instantiated once and reused every SHIFT cycle; this is the shared datapath resource being sequenced.
- Count register width: SW.

Test Plan:
- in_a=100 (0x64), S=3, out_ready=1:
  - out_valid 4 cycles after accept.
  - out_res=12 (0x0C) in both builds.
- in_a=-7 (0xF9), S=1:
  - Without the macro: out_res=-4 (0xFC).
  - With POW2_DIVIDE_ROUND_TO_ZERO_EN: out_res=-3 (0xFD).
- in_a=-128 (0x80), S=7 → out_res=-1 (0xFF) in both builds. Then in_a=-1, S=7 → -1 without the macro, 0 with it.
- in_a=5, S=0:
  - out_valid exactly 1 cycle after accept, out_res=5.
  - busy high for 1 cycle only, with out_ready=1.
- Backpressure: in_a=64, S=2, out_ready=0 for 3 cycles in DONE:
  - out_valid=1 and out_res=16 stable throughout.
  - in_ready=0; a concurrent in_valid is ignored.
  - With out_ready=1, the next cycle is IDLE.
- Reset in mid-SHIFT (S=5, rst pulsed at the 2nd shift cycle):
  - Async return: out_valid=0, busy=0, in_ready=1.
  - A following request in_a=-32, S=2 yields -8.
- Randomized sweep: 200 requests comparing against a >>> S (or a / 2**S when the macro is defined).

Source files
------------

// File: rtl/pow2_divide_sequencer_pkg.sv
// Shared types for the pow2 divide sequencer: FSM state encoding and reset constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package pow2_divide_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Every bit of the data register and result register comes out of reset at this value.
  localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/pow2_divide_sequencer_if.sv
// Request/result handshake bundle between requester, engine and consumer.
// Latency: n/a (wires only).
// Backpressure: in_ready gates requests, and out_ready holds results.
interface pow2_divide_sequencer_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) ();

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [SW-1:0] in_s;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_res;

  // Environment side: issues requests and consumes results.
  modport master (
    output in_valid, in_a, in_s, out_ready,
    input  in_ready, out_valid, out_res
  );

  // Engine side.
  modport slave (
    input  in_valid, in_a, in_s, out_ready,
    output in_ready, out_valid, out_res
  );

endinterface

// File: rtl/pow2_divide_sequencer_arsh.sv
// Single-bit arithmetic right shift; this is the shared datapath stage reused every SHIFT cycle.
// Latency: combinational.
// Backpressure: none.
module arithmetic_right_shift_by_1 #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  output logic [N-1:0] y_o
);

  // Replicate the sign bit into the vacated MSB.
  assign y_o = {a_i[N-1], a_i[N-1:1]};

endmodule

// File: rtl/pow2_divide_sequencer.sv
// Signed divide by 2^S, one arithmetic shift per clock. Define POW2_DIVIDE_ROUND_TO_ZERO_EN to get truncating rounding.
// Latency: out_valid is high S+1 cycles after the accept edge. Throughput is one result every S+2 cycles.
// Backpressure: a request is accepted only in IDLE. The result is held in DONE until out_ready.
module pow2_divide_sequencer
  import pow2_divide_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  pow2_divide_sequencer_if.slave  bus,
  output logic                    busy
);

  state_e        state_q;
  logic [N-1:0]  data_q;
  logic [N-1:0]  out_res_q;
  logic [SW-1:0] cnt_q;
  logic          out_valid_q;
  logic          busy_q;

  logic [N-1:0]  data_shift;
  logic [SW-1:0] s_acc;
  logic [N-1:0]  a_acc;

  // The one shifter that every SHIFT cycle reuses.
  arithmetic_right_shift_by_1 #(.N(N)) u_arsh (
    .a_i (data_q),
    .y_o (data_shift)
  );

  // A shift amount wider than N-1 is only encodable when N is not a power of two. Clamp it in that case.
  generate
    if ((1 << SW) > N) begin : g_sat
      localparam logic [SW-1:0] S_MAX = SW'(N - 1);
      assign s_acc = (bus.in_s > S_MAX) ? S_MAX : bus.in_s;
    end else begin : g_nosat
      assign s_acc = bus.in_s;
    end
  endgenerate

`ifdef POW2_DIVIDE_ROUND_TO_ZERO_EN
  // Add 2^S-1 to a negative dividend so that the floor shift truncates toward zero.
  // The largest sum is -1 + 2^(N-1) - 1, so the addition cannot wrap.
  logic [N-1:0] bias;
  assign bias  = ~({N{1'b1}} << s_acc);
  assign a_acc = bus.in_a[N-1] ? (bus.in_a + bias) : bus.in_a;
`else
  // Floor division: the dividend is loaded unchanged.
  assign a_acc = bus.in_a;
`endif

  // Sequencer: accept in IDLE, shift once per cycle, then present and hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= {N{DATA_RST_BIT}};
      out_res_q   <= {N{DATA_RST_BIT}};
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_q <= a_acc;
            cnt_q  <= s_acc;
            busy_q <= 1'b1;
            if (s_acc == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_res_q   <= a_acc;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= data_shift;
          cnt_q  <= cnt_q - SW'(1);
          if (cnt_q == SW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_res_q   <= data_shift;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pow2_divide_sequencer.sv
// Directed and random checks of pow2_divide_sequencer against a reference divide model.
// Latency: n/a.
// Backpressure: the bench stalls out_ready to exercise the hold behaviour in DONE.
module tb_pow2_divide_sequencer;

  localparam int N  = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  pow2_divide_sequencer_if #(.N(N), .SW(SW)) bus ();

  pow2_divide_sequencer #(.N(N), .SW(SW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] sb_q[$];

  // Reference model: floor division by default, truncating division with the rounding build.
  function automatic logic [N-1:0] model(input logic [N-1:0] a, input int s);
    int ai;
    int r;
    ai = int'($signed(a));
`ifdef POW2_DIVIDE_ROUND_TO_ZERO_EN
    r = ai / (1 << s);
`else
    r = ai >>> s;
`endif
    return r[N-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge. It is accepted at the next posedge, and its expected result goes on the scoreboard.
  task automatic send(input logic [N-1:0] a, input int s);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_s     = SW'(s);
    sb_q.push_back(model(a, s));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid rises. The wait is bounded.
  task automatic wait_out(input int s);
    int cyc;
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, s + 1);
  endtask

  task automatic check_result(input string tag);
    logic [N-1:0] exp;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, {24'd0, bus.out_res}, {24'd0, exp});
    end
  endtask

  // Run one full transaction with out_ready held high.
  task automatic req(input string tag, input logic [N-1:0] a, input int s);
    send(a, s);
    wait_out(s);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    check_result(tag);
    @(negedge clk);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [N-1:0] exp16;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_s      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_res", {24'd0, bus.out_res}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed cases
    req("a100_s3", 8'd100, 3);
    req("am7_s1", 8'hF9, 1);
    req("am128_s7", 8'h80, 7);
    req("am1_s7", 8'hFF, 7);
    req("a5_s0", 8'd5, 0);
    req("a127_s0", 8'd127, 0);
    req("a127_s7", 8'd127, 7);

    // Backpressure: stall for three cycles in DONE while a stray request is offered.
    bus.out_ready = 1'b0;
    send(8'd64, 2);
    wait_out(2);
    exp16 = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_out_res", {24'd0, bus.out_res}, {24'd0, exp16});
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_a     = 8'h7F;
      bus.in_s     = '0;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_hold_res", {24'd0, bus.out_res}, 32'd16);
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("bp_stray_ignored", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset during the second shift cycle
    send(8'h55, 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    req("am32_s2", 8'hE0, 2);

    // Random sweep
    for (int k = 0; k < 200; k++) begin
      logic [N-1:0] ra;
      int rs;
      ra = N'($urandom);
      rs = $urandom_range(0, N - 1);
      req("rand", ra, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
